// File: rtl/exec_unit_dtypes.sv
// Shared execution-unit datatypes: icon address/channel types and the fetch-controller state encoding.
package exec_unit_dtypes;

   localparam int ICON_ADDR_WIDTH = 8;
   localparam int DATA_WIDTH      = 16;

   typedef logic [ICON_ADDR_WIDTH-1:0] type_icon_addr;

   typedef struct packed {
      type_icon_addr         addr;
      logic [DATA_WIDTH-1:0] data;
      logic                  valid;
   } type_icon_channel;

   typedef struct packed {
      logic ready;
   } type_icon_rx_channel;

   typedef enum logic [1:0] {
      IFS_IDLE,
      IFS_READ,
      IFS_WRITE
   } type_icon_fetch_state;

endpackage

// File: rtl/icon_fetch_ctrl_fifo.sv
// Circular address FIFO for icon_fetch_ctrl. With ICON_FETCH_DUP_FILTER_EN it also
// reports, per entry, whether a live entry holds the compare address.
module icon_fetch_fifo
   import exec_unit_dtypes::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                push,
   input  type_icon_addr       push_addr,
   input  logic                pop,
`ifdef ICON_FETCH_DUP_FILTER_EN
   input  type_icon_addr       cmp_addr,
   output logic [DEPTH-1:0]    match,
`endif
   output type_icon_addr       head_addr,
   output logic                full,
   output logic                empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   type_icon_addr   mem_q [DEPTH];
   type_icon_addr   mem_d [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_addr;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_addr = mem_q[rd_ptr_q];
   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);

`ifdef ICON_FETCH_DUP_FILTER_EN
   // An entry is live when its distance from the read pointer is below the fill count.
   always_comb begin
      match = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match[i] = ({1'b0, PW'(i) - rd_ptr_q} < count_q) && (mem_q[i] == cmp_addr);
      end
   end
`endif

endmodule

// File: rtl/icon_fetch_ctrl.sv
// Interconnect fetch initiator: polls a producer TX buffer for queued operand addresses and
// forwards hits to the consumer write channel. Optional feature: ICON_FETCH_DUP_FILTER_EN.
//
// state     | meaning
// IFS_IDLE  | waiting for a queued request; pops the head when one is present
// IFS_READ  | strobing rd_ready for cur_addr until rd_valid or the poll limit
// IFS_WRITE | presenting {cur_addr, data_q} on wr until wr_rx.ready
module icon_fetch_ctrl
   import exec_unit_dtypes::*;
#(
   parameter int REQ_DEPTH = 4,
   parameter int MAX_POLL  = 15
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  type_icon_addr         req_addr,
   output type_icon_addr         rd_addr,
   output logic                  rd_ready,
   input  logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  rd_valid,
   output type_icon_channel      wr,
   input  type_icon_rx_channel   wr_rx,
   output logic                  busy,
   output logic                  timeout,
   output logic                  dup_drop
);

   localparam int              PCW       = $clog2(MAX_POLL + 1);
   localparam logic [PCW-1:0]  POLL_LAST = PCW'(MAX_POLL);

   type_icon_fetch_state  state_q, state_d;
   logic [PCW-1:0]        poll_q, poll_d;
   type_icon_addr         cur_addr_q, cur_addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;

   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   type_icon_addr fifo_push_addr, fifo_head;
   logic          requeue_now, req_fire, is_dup;

`ifdef ICON_FETCH_DUP_FILTER_EN
   logic [REQ_DEPTH-1:0] fifo_match;
   assign is_dup   = (|fifo_match) | ((state_q != IFS_IDLE) & (cur_addr_q == req_addr));
   assign dup_drop = req_fire & is_dup;
`else
   assign is_dup   = 1'b0;
   assign dup_drop = 1'b0;
`endif

   // Requeue owns the FIFO write port for its cycle, so the external request is stalled.
   assign requeue_now    = (state_q == IFS_READ) & ~rd_valid & (poll_q == POLL_LAST) & ~fifo_full;
   assign req_ready      = ~fifo_full & ~requeue_now;
   assign req_fire       = req_valid & req_ready;
   assign fifo_push      = (req_fire & ~is_dup) | requeue_now;
   assign fifo_push_addr = requeue_now ? cur_addr_q : req_addr;
   assign fifo_pop       = (state_q == IFS_IDLE) & ~fifo_empty;
   assign timeout        = requeue_now;
   assign busy           = (state_q != IFS_IDLE) | ~fifo_empty;

   icon_fetch_fifo #(
      .DEPTH (REQ_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_addr (fifo_push_addr),
      .pop       (fifo_pop),
`ifdef ICON_FETCH_DUP_FILTER_EN
      .cmp_addr  (req_addr),
      .match     (fifo_match),
`endif
      .head_addr (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_d    = state_q;
      poll_d     = poll_q;
      cur_addr_d = cur_addr_q;
      data_d     = data_q;
      rd_ready   = 1'b0;
      rd_addr    = '0;
      wr         = '0;
      unique case (state_q)
         IFS_IDLE: begin
            if (!fifo_empty) begin
               cur_addr_d = fifo_head;
               poll_d     = '0;
               state_d    = IFS_READ;
            end
         end
         IFS_READ: begin
            rd_ready = 1'b1;
            rd_addr  = cur_addr_q;
            if (rd_valid) begin
               data_d  = rd_data;
               state_d = IFS_WRITE;
            end else if (poll_q != POLL_LAST) begin
               poll_d = poll_q + 1'b1;
            end else if (!fifo_full) begin
               state_d = IFS_IDLE;
            end else begin
               // Nowhere to requeue: restart the poll window on the same address.
               poll_d = '0;
            end
         end
         IFS_WRITE: begin
            wr.valid = 1'b1;
            wr.addr  = cur_addr_q;
            wr.data  = data_q;
            if (wr_rx.ready) begin
               state_d = IFS_IDLE;
            end
         end
         default: state_d = IFS_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IFS_IDLE;
         poll_q     <= '0;
         cur_addr_q <= '0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         poll_q     <= poll_d;
         cur_addr_q <= cur_addr_d;
         data_q     <= data_d;
      end
   end

endmodule

// File: tb/tb_icon_fetch_ctrl.sv
// Self-checking bench for icon_fetch_ctrl: vector table, hand-written corner sequences and a
// randomized run against a queue-based reference model.
module tb_icon_fetch_ctrl;
   import exec_unit_dtypes::*;

   localparam int REQ_DEPTH = 4;
   localparam int MAX_POLL  = 15;
`ifdef ICON_FETCH_DUP_FILTER_EN
   localparam bit DUP_EN = 1'b1;
`else
   localparam bit DUP_EN = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  reset_n;
   logic                  req_valid;
   logic                  req_ready;
   type_icon_addr         req_addr;
   type_icon_addr         rd_addr;
   logic                  rd_ready;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   type_icon_channel      wr;
   type_icon_rx_channel   wr_rx;
   logic                  busy;
   logic                  timeout;
   logic                  dup_drop;

   int checks = 0;
   int errors = 0;

   icon_fetch_ctrl #(
      .REQ_DEPTH (REQ_DEPTH),
      .MAX_POLL  (MAX_POLL)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .rd_addr   (rd_addr),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .wr        (wr),
      .wr_rx     (wr_rx),
      .busy      (busy),
      .timeout   (timeout),
      .dup_drop  (dup_drop)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic                  rv;
      type_icon_addr         ra;
      logic                  dv;
      logic [DATA_WIDTH-1:0] dd;
      logic                  wrdy;
      logic                  e_req_ready;
      logic                  e_rd_ready;
      type_icon_addr         e_rd_addr;
      logic                  e_wv;
      type_icon_addr         e_wa;
      logic [DATA_WIDTH-1:0] e_wd;
      logic                  e_busy;
   } vec_t;

   vec_t vecs [15];

   type_icon_addr drained [$];

   // reference model state
   type_icon_addr         mq [$];
   int                    m_phase;
   int                    m_poll;
   type_icon_addr         m_cur;
   logic [DATA_WIDTH-1:0] m_data;

   logic                  r_rv, r_dv, r_wrdy;
   type_icon_addr         r_ra;
   logic [DATA_WIDTH-1:0] r_dd;
   logic                  e_full, e_req, e_ready, e_inq, e_dup, e_fire;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic type_icon_channel mkwr(input type_icon_addr a, input logic [DATA_WIDTH-1:0] d,
                                             input logic v);
      type_icon_channel c;
      c.addr  = a;
      c.data  = d;
      c.valid = v;
      return c;
   endfunction

   task automatic drive(input logic rv, input type_icon_addr ra, input logic dv,
                        input logic [DATA_WIDTH-1:0] dd, input logic wrdy);
      req_valid   = rv;
      req_addr    = ra;
      rd_valid    = dv;
      rd_data     = dd;
      wr_rx.ready = wrdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic do_reset();
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic drain(input int budget, input string tag);
      logic done;
      done = 1'b0;
      drained.delete();
      for (int k = 0; k < budget; k++) begin
         drive(1'b0, '0, 1'b1, DATA_WIDTH'($urandom), 1'b1);
         at_neg();
         if (wr.valid) drained.push_back(wr.addr);
         done = !busy;
         tick();
         if (done) break;
      end
      chk({tag, "_drain_idle"}, done, 1'b1);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 8'h3C, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0};
      vecs[1]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b1};
      vecs[2]  = '{1'b0, 8'h00, 1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h00, 16'h0000, 1'b1};
      vecs[3]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3C, 16'hDEAD, 1'b1};
      vecs[4]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0};
      vecs[5]  = '{1'b1, 8'h51, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0};
      vecs[6]  = '{1'b1, 8'h77, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b1};
      vecs[7]  = '{1'b0, 8'h00, 1'b1, 16'h1111, 1'b0, 1'b1, 1'b1, 8'h51, 1'b0, 8'h00, 16'h0000, 1'b1};
      vecs[8]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h51, 16'h1111, 1'b1};
      vecs[9]  = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h51, 16'h1111, 1'b1};
      vecs[10] = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b1};
      vecs[11] = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 8'h00, 16'h0000, 1'b1};
      vecs[12] = '{1'b0, 8'h00, 1'b1, 16'h2222, 1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 8'h00, 16'h0000, 1'b1};
      vecs[13] = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h77, 16'h2222, 1'b1};
      vecs[14] = '{1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0};

      // reset state
      reset_n = 1'b0;
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      tick();
      chk("rst_rd_ready", rd_ready, 1'b0);
      chk("rst_wr", wr, '0);
      chk("rst_busy", busy, 1'b0);
      tick();
      reset_n = 1'b1;
      at_neg();
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_timeout", timeout, 1'b0);
      chk("rst_dup_drop", dup_drop, 1'b0);
      chk("rst_rd_addr", rd_addr, '0);
      tick();

      // vector table: single fetch latency, then back-to-back fetches with a write stall
      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].rv, vecs[i].ra, vecs[i].dv, vecs[i].dd, vecs[i].wrdy);
         at_neg();
         chk($sformatf("vec%0d_req_ready", i), req_ready, vecs[i].e_req_ready);
         chk($sformatf("vec%0d_rd_ready", i), rd_ready, vecs[i].e_rd_ready);
         chk($sformatf("vec%0d_rd_addr", i), rd_addr, vecs[i].e_rd_addr);
         chk($sformatf("vec%0d_wr", i), wr, mkwr(vecs[i].e_wa, vecs[i].e_wd, vecs[i].e_wv));
         chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
         chk($sformatf("vec%0d_timeout", i), timeout, 1'b0);
         tick();
      end

      // poll timeout requeues A behind B
      drive(1'b1, 8'h0A, 1'b0, '0, 1'b0); at_neg(); tick();
      drive(1'b1, 8'h0B, 1'b0, '0, 1'b0); at_neg(); tick();
      for (int k = 1; k <= 16; k++) begin
         drive(1'b0, '0, 1'b0, '0, 1'b0);
         at_neg();
         chk("t2_rd_addr", rd_addr, 8'h0A);
         chk($sformatf("t2_timeout_poll%0d", k), timeout, k == 16);
         if (k == 16) chk("t2_req_ready_requeue", req_ready, 1'b0);
         tick();
      end
      drive(1'b0, '0, 1'b0, '0, 1'b0); at_neg();
      chk("t2_idle_rd_ready", rd_ready, 1'b0);
      chk("t2_idle_busy", busy, 1'b1);
      tick();
      drive(1'b0, '0, 1'b1, 16'hBBBB, 1'b0); at_neg();
      chk("t2_second_fetch_addr", rd_addr, 8'h0B);
      tick();
      drive(1'b0, '0, 1'b0, '0, 1'b1); at_neg();
      chk("t2_write_b", wr, mkwr(8'h0B, 16'hBBBB, 1'b1));
      tick();
      drive(1'b0, '0, 1'b0, '0, 1'b0); at_neg(); tick();
      drive(1'b0, '0, 1'b1, 16'hAAAA, 1'b0); at_neg();
      chk("t2_third_fetch_addr", rd_addr, 8'h0A);
      tick();
      drive(1'b0, '0, 1'b0, '0, 1'b1); at_neg();
      chk("t2_write_a", wr, mkwr(8'h0A, 16'hAAAA, 1'b1));
      tick();
      drive(1'b0, '0, 1'b0, '0, 1'b0); at_neg();
      chk("t2_end_busy", busy, 1'b0);
      tick();

      // fill the FIFO, stall the write, then poll at MAX_POLL with FIFO full
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, type_icon_addr'(8'h40 + i), i == 2, 16'h1234, 1'b0);
         at_neg();
         chk("t3_fill_ready", req_ready, 1'b1);
         tick();
      end
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 8'h45, 1'b0, '0, 1'b0);
         at_neg();
         chk("t3_full_ready", req_ready, 1'b0);
         chk("t3_wr_stable", wr, mkwr(8'h40, 16'h1234, 1'b1));
         tick();
      end
      drive(1'b1, 8'h45, 1'b0, '0, 1'b1); at_neg();
      chk("t3_release_ready", req_ready, 1'b0);
      chk("t3_release_wr", wr, mkwr(8'h40, 16'h1234, 1'b1));
      tick();
      drive(1'b1, 8'h45, 1'b0, '0, 1'b0); at_neg();
      chk("t3_idle_ready", req_ready, 1'b0);
      chk("t3_idle_wr", wr, '0);
      tick();
      drive(1'b1, 8'h45, 1'b0, '0, 1'b0); at_neg();
      chk("t3_slot_freed_ready", req_ready, 1'b1);
      chk("t3_next_rd_addr", rd_addr, 8'h41);
      tick();
      for (int k = 0; k < 20; k++) begin
         drive(1'b0, '0, 1'b0, '0, 1'b0);
         at_neg();
         chk("t6_no_timeout_full", timeout, 1'b0);
         chk("t6_stay_read", rd_addr, 8'h41);
         chk("t6_full_ready", req_ready, 1'b0);
         tick();
      end
      drive(1'b0, '0, 1'b1, 16'h6666, 1'b0); at_neg();
      chk("t6_hit_addr", rd_addr, 8'h41);
      tick();
      drive(1'b0, '0, 1'b0, '0, 1'b1); at_neg();
      chk("t6_write", wr, mkwr(8'h41, 16'h6666, 1'b1));
      tick();
      drain(60, "t3");
      chk("t3_drain_count", drained.size(), 4);
      for (int i = 0; i < drained.size() && i < 4; i++)
         chk($sformatf("t3_drain_order%0d", i), drained[i], 8'h42 + i);

      // asynchronous reset in the middle of a WRITE with a request still queued
      drive(1'b1, 8'h61, 1'b0, '0, 1'b0); at_neg(); tick();
      drive(1'b1, 8'h62, 1'b0, '0, 1'b0); at_neg(); tick();
      drive(1'b0, '0, 1'b1, 16'h5A5A, 1'b0); at_neg(); tick();
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      at_neg();
      chk("t4_pre_wr_valid", wr.valid, 1'b1);
      at_neg();
      #2;
      reset_n = 1'b0;
      #1;
      chk("t4_async_wr", wr, '0);
      chk("t4_async_rd_ready", rd_ready, 1'b0);
      chk("t4_async_busy", busy, 1'b0);
      @(negedge clk);
      #3;
      reset_n = 1'b1;
      tick();
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, '0, 1'b0, '0, 1'b1);
         at_neg();
         chk("t4_no_stale_rd", rd_ready, 1'b0);
         chk("t4_no_stale_wr", wr.valid, 1'b0);
         chk("t4_post_busy", busy, 1'b0);
         chk("t4_post_ready", req_ready, 1'b1);
         tick();
      end

      // duplicate request while the same address is being read
      drive(1'b1, 8'h22, 1'b0, '0, 1'b0); at_neg();
      chk("t5_first_no_drop", dup_drop, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, '0, 1'b0); at_neg(); tick();
      drive(1'b1, 8'h22, 1'b0, '0, 1'b0); at_neg();
      chk("t5_dup_ready", req_ready, 1'b1);
      chk("t5_dup_drop", dup_drop, DUP_EN);
      tick();
      drain(40, "t5");
      chk("t5_write_count", drained.size(), DUP_EN ? 1 : 2);
      for (int i = 0; i < drained.size(); i++)
         chk("t5_write_addr", drained[i], 8'h22);

      // randomized run against the reference model
      do_reset();
      mq.delete();
      m_phase = 0;
      m_poll  = 0;
      m_cur   = '0;
      m_data  = '0;
      for (int seg = 0; seg < 4; seg++) begin
         for (int n = 0; n < 250; n++) begin
            r_rv   = (seg == 3) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
            r_ra   = type_icon_addr'(8'h10 + $urandom_range(0, 3));
            case (seg)
               0:       r_dv = ($urandom_range(0, 1) == 0);
               1:       r_dv = ($urandom_range(0, 2) == 0);
               2:       r_dv = ($urandom_range(0, 39) == 0);
               default: r_dv = ($urandom_range(0, 11) == 0);
            endcase
            r_dd   = DATA_WIDTH'($urandom);
            r_wrdy = ($urandom_range(0, 3) != 0);
            drive(r_rv, r_ra, r_dv, r_dd, r_wrdy);
            at_neg();

            e_full  = (mq.size() == REQ_DEPTH);
            e_req   = (m_phase == 1) && !r_dv && (m_poll == MAX_POLL) && !e_full;
            e_ready = !e_full && !e_req;
            e_inq   = 1'b0;
            foreach (mq[i]) if (mq[i] == r_ra) e_inq = 1'b1;
            e_dup   = DUP_EN && r_rv && (e_inq || (m_phase != 0 && m_cur == r_ra));
            e_fire  = r_rv && e_ready;

            chk("rnd_req_ready", req_ready, e_ready);
            chk("rnd_rd_ready", rd_ready, m_phase == 1);
            chk("rnd_rd_addr", rd_addr, (m_phase == 1) ? m_cur : '0);
            chk("rnd_wr", wr, (m_phase == 2) ? mkwr(m_cur, m_data, 1'b1) : mkwr('0, '0, 1'b0));
            chk("rnd_busy", busy, (m_phase != 0) || (mq.size() != 0));
            chk("rnd_timeout", timeout, e_req);
            chk("rnd_dup_drop", dup_drop, e_fire && e_dup);

            case (m_phase)
               0: if (mq.size() != 0) begin
                     m_cur   = mq.pop_front();
                     m_poll  = 0;
                     m_phase = 1;
                  end
               1: if (r_dv) begin
                     m_data  = r_dd;
                     m_phase = 2;
                  end else if (m_poll < MAX_POLL) begin
                     m_poll++;
                  end else if (!e_full) begin
                     mq.push_back(m_cur);
                     m_phase = 0;
                  end else begin
                     m_poll = 0;
                  end
               default: if (r_wrdy) m_phase = 0;
            endcase
            if (e_fire && !e_dup) mq.push_back(r_ra);
            tick();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
